// File: rtl/lstm_elementwise_unit_pkg.sv
// Shared types and fixed-point helpers for the LSTM element-wise datapath.
// Helpers take the word width and fraction bits as arguments so one package serves any instance width up to 32 bits.
package lstm_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL       = 3'd1,
        ACC       = 3'd2,
        TANH_WAIT = 3'd3,
        WAIT_O    = 3'd4,
        HMUL      = 3'd5,
        OUT       = 3'd6
    } ew_state_t;

    // 1.0 and the tanh saturation point 4.0, both in Q.8 (the tanh table's native format).
    localparam int unsigned ONE_FX     = 32'd256;
    localparam int unsigned TANH_SAT_X = 32'd1024;

    // Clamp a wide signed value into the signed range of a dw-bit word.
    function automatic logic signed [31:0] sat_fx(input logic signed [63:0] v, input int unsigned dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 32'd1));
        if (v > hi) begin
            return hi[31:0];
        end else if (v < lo) begin
            return lo[31:0];
        end else begin
            return v[31:0];
        end
    endfunction

    // Full-precision signed product, rescaled by the fraction bits and saturated.
    function automatic logic signed [31:0] fx_mul(input logic signed [31:0] a, input logic signed [31:0] b,
                                                  input int unsigned dw, input int unsigned fb);
        logic signed [63:0] prod;
        prod = 64'(a) * 64'(b);
        return sat_fx(prod >>> fb, dw);
    endfunction

    // tanh sampled every 0.25 on [0, 4], Q.8, rounded to nearest; non-decreasing by construction.
    function automatic logic [8:0] tanh_knot(input logic [4:0] idx);
        case (idx)
            5'd0:    return 9'd0;
            5'd1:    return 9'd63;
            5'd2:    return 9'd118;
            5'd3:    return 9'd163;
            5'd4:    return 9'd195;
            5'd5:    return 9'd217;
            5'd6:    return 9'd232;
            5'd7:    return 9'd241;
            5'd8:    return 9'd247;
            5'd9:    return 9'd250;
            5'd10:   return 9'd253;
            5'd11:   return 9'd254;
            5'd12:   return 9'd255;
            5'd13:   return 9'd255;
            5'd14:   return 9'd256;
            5'd15:   return 9'd256;
            default: return 9'd256;
        endcase
    endfunction

endpackage

// File: rtl/lstm_elementwise_unit_if.sv
// Element-wise handshake bundle between the LSTM control unit / FIFOs and the element-wise unit.
interface lstm_elementwise_unit_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start_EW;
    logic [3:0]            seq_idx;
    logic [DATA_WIDTH-1:0] input_gate_data;
    logic [DATA_WIDTH-1:0] candidate_gate_data;
    logic [DATA_WIDTH-1:0] forget_gate_data;
    logic [DATA_WIDTH-1:0] cell_prev_data;
    logic [DATA_WIDTH-1:0] output_gate_data;
    logic                  output_gate_data_valid;
    logic [DATA_WIDTH-1:0] cell_state;
    logic                  cell_state_valid;
    logic                  cell_fifo_wr_en;
    logic                  hyperbolic_done;
    logic [DATA_WIDTH-1:0] hidden_state;
    logic                  hidden_state_valid;
    logic                  busy;
    logic                  overrun_err;

    modport master (
        output start_EW, seq_idx, input_gate_data, candidate_gate_data, forget_gate_data,
               cell_prev_data, output_gate_data, output_gate_data_valid,
        input  cell_state, cell_state_valid, cell_fifo_wr_en, hyperbolic_done,
               hidden_state, hidden_state_valid, busy, overrun_err
    );

    modport slave (
        input  start_EW, seq_idx, input_gate_data, candidate_gate_data, forget_gate_data,
               cell_prev_data, output_gate_data, output_gate_data_valid,
        output cell_state, cell_state_valid, cell_fifo_wr_en, hyperbolic_done,
               hidden_state, hidden_state_valid, busy, overrun_err
    );
endinterface

// File: rtl/lstm_elementwise_unit_tanh.sv
// Piecewise-linear tanh with 0.25-wide segments, odd-symmetric, exactly +/-1.0 for |x| >= 4.0.
// Result and done emerge exactly TANH_LAT cycles after start; one operation in flight.
module lstm_tanh_pwl
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int TANH_LAT   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic                         done,
    output logic signed [DATA_WIDTH-1:0] y
);
    // Rescale between the instance format and the table's Q.8 format.
    localparam int SH_DN = (FRAC_BITS >= 8) ? FRAC_BITS - 8 : 0;
    localparam int SH_UP = (FRAC_BITS < 8) ? 8 - FRAC_BITS : 0;

    logic                         neg_s;
    logic [DATA_WIDTH:0]          mag_s;
    logic [31:0]                  a_q8_s;
    logic                         sat_s;
    logic [4:0]                   seg_s;
    logic [5:0]                   frac_s;
    logic [8:0]                   y0_s;
    logic [8:0]                   y1_s;
    logic [15:0]                  interp_s;
    logic [15:0]                  y_q8_s;
    logic [31:0]                  y_mag_s;
    logic signed [DATA_WIDTH-1:0] y_res_s;

    logic signed [DATA_WIDTH-1:0] pipe_r [TANH_LAT];
    logic [TANH_LAT-1:0]          vld_r;

    // Magnitude lookup and linear interpolation, sign restored at the end.
    always_comb begin
        neg_s    = x[DATA_WIDTH-1];
        mag_s    = {x[DATA_WIDTH-1], x};
        if (neg_s) begin
            mag_s = (~{x[DATA_WIDTH-1], x}) + {{DATA_WIDTH{1'b0}}, 1'b1};
        end else begin
            mag_s = {x[DATA_WIDTH-1], x};
        end
        a_q8_s   = (32'(mag_s) >> SH_DN) << SH_UP;
        sat_s    = (a_q8_s >= TANH_SAT_X);
        seg_s    = {1'b0, a_q8_s[9:6]};
        frac_s   = a_q8_s[5:0];
        y0_s     = tanh_knot(seg_s);
        y1_s     = tanh_knot(seg_s + 5'd1);
        interp_s = 16'(y0_s) + ((16'(y1_s - y0_s) * 16'(frac_s)) >> 6);
        if (sat_s) begin
            y_q8_s = 16'(ONE_FX);
        end else begin
            y_q8_s = interp_s;
        end
        y_mag_s  = (32'(y_q8_s) << SH_DN) >> SH_UP;
        if (neg_s) begin
            y_res_s = DATA_WIDTH'(32'd0 - y_mag_s);
        end else begin
            y_res_s = DATA_WIDTH'(y_mag_s);
        end
    end

    // Fixed-latency delay line for the result and its done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int k = 0; k < TANH_LAT; k++) begin
                pipe_r[k] <= '0;
            end
        end else begin
            vld_r[0] <= start;
            if (start) begin
                pipe_r[0] <= y_res_s;
            end
            for (int k = 1; k < TANH_LAT; k++) begin
                vld_r[k]  <= vld_r[k-1];
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    assign done = vld_r[TANH_LAT-1];
    assign y    = pipe_r[TANH_LAT-1];

endmodule

// File: rtl/lstm_elementwise_unit.sv
// LSTM element-wise unit: c = f*c_prev + i*g, then h = o*tanh(c), answering the control unit's EW handshake.
module lstm_elementwise_unit
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int TANH_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lstm_elementwise_unit_if.slave  ew
);
    typedef logic signed [DATA_WIDTH-1:0] word_t;

    ew_state_t state_r;
    ew_state_t state_next_s;
    logic      tanh_start_s;
    logic      tanh_done_s;
    word_t     tanh_y_s;

    word_t i_r, g_r, f_r, cp_r, p1_r, p2_r, t_r, o_r;
    word_t cell_r, hidden_r;
    logic  cell_valid_r, hyp_done_r, hidden_valid_r, busy_r, overrun_r;

    word_t                 p1_s, p2_s, c_next_s, h_next_s;
    logic signed [DATA_WIDTH:0] sum_s;

    // Product and accumulate arithmetic on the registered operands.
    always_comb begin
        p1_s     = word_t'(fx_mul(32'(f_r), 32'(cp_r), DATA_WIDTH, FRAC_BITS));
        p2_s     = word_t'(fx_mul(32'(i_r), 32'(g_r), DATA_WIDTH, FRAC_BITS));
        sum_s    = {p1_r[DATA_WIDTH-1], p1_r} + {p2_r[DATA_WIDTH-1], p2_r};
        c_next_s = word_t'(sat_fx(64'(sum_s), DATA_WIDTH));
        h_next_s = word_t'(fx_mul(32'(o_r), 32'(t_r), DATA_WIDTH, FRAC_BITS));
    end

    lstm_tanh_pwl #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .TANH_LAT   (TANH_LAT)
    ) u_tanh (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tanh_start_s),
        .x     (c_next_s),
        .done  (tanh_done_s),
        .y     (tanh_y_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; tanh is launched from ACC using the combinational sum.
    always_comb begin
        state_next_s = state_r;
        tanh_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ew.start_EW) begin
                    state_next_s = MUL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL:  state_next_s = ACC;
            ACC: begin
                tanh_start_s = 1'b1;
                state_next_s = TANH_WAIT;
            end
            TANH_WAIT: begin
                if (tanh_done_s) begin
                    state_next_s = WAIT_O;
                end else begin
                    state_next_s = TANH_WAIT;
                end
            end
            WAIT_O: begin
                if (ew.output_gate_data_valid) begin
                    state_next_s = HMUL;
                end else begin
                    state_next_s = WAIT_O;
                end
            end
            HMUL:    state_next_s = OUT;
            OUT:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand capture, result registers and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_r            <= '0;
            g_r            <= '0;
            f_r            <= '0;
            cp_r           <= '0;
            p1_r           <= '0;
            p2_r           <= '0;
            t_r            <= '0;
            o_r            <= '0;
            cell_r         <= '0;
            hidden_r       <= '0;
            cell_valid_r   <= 1'b0;
            hyp_done_r     <= 1'b0;
            hidden_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            cell_valid_r   <= 1'b0;
            hyp_done_r     <= 1'b0;
            hidden_valid_r <= 1'b0;
            busy_r         <= (state_next_s != IDLE);
            if (ew.start_EW && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (ew.start_EW) begin
                        i_r  <= word_t'(ew.input_gate_data);
                        g_r  <= word_t'(ew.candidate_gate_data);
                        f_r  <= word_t'(ew.forget_gate_data);
                        cp_r <= (ew.seq_idx == 4'd0) ? '0 : word_t'(ew.cell_prev_data);
                    end
                end
                MUL: begin
                    p1_r <= p1_s;
                    p2_r <= p2_s;
                end
                ACC: begin
                    cell_r       <= c_next_s;
                    cell_valid_r <= 1'b1;
                end
                TANH_WAIT: begin
                    if (tanh_done_s) begin
                        t_r        <= tanh_y_s;
                        hyp_done_r <= 1'b1;
                    end
                end
                WAIT_O: begin
                    if (ew.output_gate_data_valid) begin
                        o_r <= word_t'(ew.output_gate_data);
                    end
                end
                HMUL: begin
                    hidden_r       <= h_next_s;
                    hidden_valid_r <= 1'b1;
                end
                OUT: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign ew.cell_state         = cell_r;
    assign ew.cell_state_valid   = cell_valid_r;
    assign ew.cell_fifo_wr_en    = cell_valid_r;
    assign ew.hyperbolic_done    = hyp_done_r;
    assign ew.hidden_state       = hidden_r;
    assign ew.hidden_state_valid = hidden_valid_r;
    assign ew.busy               = busy_r;
    assign ew.overrun_err        = overrun_r;

endmodule

// File: tb/tb_lstm_elementwise_unit.sv
// Table-driven bench for lstm_elementwise_unit plus overrun and mid-operation reset sequences.
module tb_lstm_elementwise_unit;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cell_cnt = 0;
    int   hid_cnt = 0;

    lstm_elementwise_unit_if #(.DATA_WIDTH(DW)) ifc ();

    lstm_elementwise_unit #(.DATA_WIDTH(DW), .FRAC_BITS(8), .TANH_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ew    (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifc.cell_state_valid) cell_cnt <= cell_cnt + 1;
        if (ifc.hidden_state_valid) hid_cnt <= hid_cnt + 1;
    end

    typedef struct {
        logic [3:0]  seq;
        logic [15:0] i, g, f, cp, o, exp_c, exp_h;
        int          tol;
        bit          o_same;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_tol(input string name, input logic [15:0] act, input logic [15:0] exp, input int tol);
        int d;
        n_checks++;
        d = int'($signed(act)) - int'($signed(exp));
        if (d < 0) d = -d;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h +/- %0d", name, act, exp, tol);
    endtask

    task automatic drive_start(input vec_t v);
        ifc.start_EW            = 1'b1;
        ifc.seq_idx             = v.seq;
        ifc.input_gate_data     = v.i;
        ifc.candidate_gate_data = v.g;
        ifc.forget_gate_data    = v.f;
        ifc.cell_prev_data      = v.cp;
    endtask

    task automatic run_op(input vec_t v, input bit inject_overrun, input string tag);
        int cyc;
        int c0;
        int h0;
        c0 = cell_cnt;
        h0 = hid_cnt;
        drive_start(v);
        tick();                             // E0
        ifc.start_EW = 1'b0;
        tick();                             // E1
        tick();                             // E2
        check({tag, " cell_valid"}, 32'(ifc.cell_state_valid), 32'd1);
        check({tag, " fifo_wr_en"}, 32'(ifc.cell_fifo_wr_en), 32'd1);
        check({tag, " cell_state"}, 32'(ifc.cell_state), 32'(v.exp_c));
        if (inject_overrun) begin
            ifc.start_EW            = 1'b1;
            ifc.seq_idx             = 4'd0;
            ifc.input_gate_data     = 16'h1111;
            ifc.forget_gate_data    = 16'h2222;
            ifc.candidate_gate_data = 16'h3333;
        end
        cyc = 0;
        do begin
            tick();
            ifc.start_EW = 1'b0;
            cyc++;
        end while (!ifc.hyperbolic_done && cyc < 20);
        check({tag, " hyp_latency"}, 32'(cyc), 32'(LAT));
        if (!v.o_same) tick();
        ifc.output_gate_data       = v.o;
        ifc.output_gate_data_valid = 1'b1;
        tick();
        ifc.output_gate_data_valid = 1'b0;
        ifc.output_gate_data       = 16'hDEAD;
        cyc = 0;
        while (!ifc.hidden_state_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, " h_latency"}, 32'(cyc), 32'd1);
        check_tol({tag, " hidden_state"}, ifc.hidden_state, v.exp_h, v.tol);
        tick();
        check({tag, " busy_idle"}, 32'(ifc.busy), 32'd0);
        check({tag, " cell_pulses"}, 32'(cell_cnt - c0), 32'd1);
        check({tag, " hid_pulses"}, 32'(hid_cnt - h0), 32'd1);
    endtask

    initial begin
        int h0;
        int cyc;
        vecs[0] = '{4'd1, 16'h0080, 16'h0080, 16'h0080, 16'h0100, 16'h0100, 16'h00C0, 16'h00A2, 8, 1'b0};
        vecs[1] = '{4'd0, 16'h0080, 16'h0080, 16'h0080, 16'h0100, 16'h0100, 16'h0040, 16'h0040, 8, 1'b1};
        vecs[2] = '{4'd1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h7FFF, 16'h0100, 0, 1'b0};
        vecs[3] = '{4'd1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0100, 16'h7FFF, 16'h0100, 0, 1'b1};
        vecs[4] = '{4'd1, 16'h0000, 16'h1234, 16'h0100, 16'hFE00, 16'h0080, 16'hFE00, 16'hFF85, 8, 1'b0};
        vecs[5] = '{4'd1, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0100, 16'h8000, 16'hFF00, 0, 1'b0};
        vecs[6] = '{4'd1, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h00C3, 2, 1'b0};
        vecs[7] = '{4'd1, 16'h0000, 16'h0000, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'hFF3D, 2, 1'b1};

        ifc.start_EW = 1'b0;
        ifc.seq_idx = 4'd0;
        ifc.input_gate_data = '0;
        ifc.candidate_gate_data = '0;
        ifc.forget_gate_data = '0;
        ifc.cell_prev_data = '0;
        ifc.output_gate_data = '0;
        ifc.output_gate_data_valid = 1'b0;

        repeat (3) tick();
        check("reset outputs", {ifc.cell_state, ifc.hidden_state}, 32'd0);
        check("reset flags", {28'd0, ifc.cell_state_valid, ifc.hyperbolic_done, ifc.busy, ifc.overrun_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) begin
            run_op(vecs[k], 1'b0, $sformatf("vec%0d", k));
        end
        check("no overrun yet", 32'(ifc.overrun_err), 32'd0);

        run_op(vecs[0], 1'b1, "overrun");
        check("overrun_err set", 32'(ifc.overrun_err), 32'd1);
        tick();
        check("overrun sticky", 32'(ifc.overrun_err), 32'd1);

        // Reset while parked in WAIT_O, then offer o: no hidden pulse may follow.
        drive_start(vecs[0]);
        tick();
        ifc.start_EW = 1'b0;
        cyc = 0;
        while (!ifc.hyperbolic_done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("rst seq hyp seen", 32'(ifc.hyperbolic_done), 32'd1);
        tick();
        h0 = hid_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("midrst outputs", {ifc.cell_state, ifc.hidden_state}, 32'd0);
        check("midrst flags", {28'd0, ifc.cell_state_valid, ifc.hyperbolic_done, ifc.busy, ifc.overrun_err}, 32'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        ifc.output_gate_data = 16'h0100;
        ifc.output_gate_data_valid = 1'b1;
        tick();
        ifc.output_gate_data_valid = 1'b0;
        repeat (6) tick();
        check("midrst no hidden pulse", 32'(hid_cnt - h0), 32'd0);
        check("midrst idle", {ifc.hidden_state, 15'd0, ifc.busy}, 32'd0);

        run_op(vecs[0], 1'b0, "post_reset");
        check("post_reset no overrun", 32'(ifc.overrun_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lstm_elementwise_unit.md
Name: lstm_elementwise_unit

Overview:
Element-wise datapath that answers the LSTM cell control unit's EW handshake.
On start_EW it latches the input, candidate and forget gate values and the previous cell state, and computes c = f*c_prev + i*g.
It then computes tanh(c), reports hyperbolic_done, waits for the output-gate value from the output FIFO, and produces h = o*tanh(c).
It pulses cell_state_valid, hyperbolic_done and hidden_state_valid in exactly the order the control unit's FSM2/FSM3 consume them, and writes c to the cell FIFO for the next sequence step.

Parameters:
DATA_WIDTH, 16, signed fixed-point word width for all data ports.
FRAC_BITS, 8, fractional bits (Q7.8 at defaults).
TANH_LAT, 2, fixed latency in cycles of the tanh sub-module (≥1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_EW  in  1  one-cycle start; operands valid in the same cycle.
seq_idx  in  4  sequence index; 0 forces c_prev to 0.
input_gate_data  in  DATA_WIDTH  i.
candidate_gate_data  in  DATA_WIDTH  g.
forget_gate_data  in  DATA_WIDTH  f.
cell_prev_data  in  DATA_WIDTH  c_prev from the cell FIFO.
output_gate_data  in  DATA_WIDTH  o from the output FIFO.
output_gate_data_valid  in  1  o is valid this cycle; driven one cycle after output_fifo_rd_en (FIFO read latency 1).
cell_state  out  DATA_WIDTH  c, held until the next computation.
cell_state_valid  out  1  one-cycle pulse.
cell_fifo_wr_en  out  1  equals cell_state_valid.
hyperbolic_done  out  1  one-cycle pulse; tanh(c) ready.
hidden_state  out  DATA_WIDTH  h, held.
hidden_state_valid  out  1  one-cycle pulse.
busy  out  1  high in every state except IDLE.
overrun_err  out  1  sticky; set when start_EW arrives while busy.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; all outputs and internal registers to 0, including overrun_err. Reset mid-operation aborts the computation with no further pulses.
- FSM states: IDLE, MUL, ACC, TANH_WAIT, WAIT_O, HMUL, OUT.
- IDLE: on start_EW=1, latch i, g, f and c_p (c_p = 0 if seq_idx==0, else cell_prev_data); go to MUL.
- MUL: register p1 = f*c_p and p2 = i*g. Each product is the full 2*DATA_WIDTH signed product, arithmetic shift right by FRAC_BITS, then saturated to the DATA_WIDTH signed range. Go to ACC.
- ACC: c = sat(p1 + p2) computed in DATA_WIDTH+1 bits. Register cell_state, assert cell_state_valid and cell_fifo_wr_en for one cycle, pulse tanh_start, go to TANH_WAIT.
- Latency: start_EW sampled at edge E0 gives cell_state_valid high during the cycle after edge E2.
- TANH_WAIT: wait for tanh_done (exactly TANH_LAT cycles after tanh_start), then register t and go to WAIT_O with hyperbolic_done high for that one cycle.
- WAIT_O: wait on output_gate_data_valid; on valid, latch o and go to HMUL. If valid arrives in the same cycle hyperbolic_done is asserted, it is accepted. Valid in any state other than WAIT_O is ignored.
- HMUL: h = sat((o*t) >>> FRAC_BITS), same product rule as MUL; go to OUT.
- OUT: register hidden_state and pulse hidden_state_valid; go to IDLE. A start_EW in the same cycle as OUT counts as overrun.
- start_EW in any non-IDLE state: ignored, overrun_err set to 1 (sticky until reset).
- Saturation bounds: max = 2^(DATA_WIDTH-1)-1, min = -2^(DATA_WIDTH-1).
- Tanh requirements:
  - odd-symmetric;
  - tanh(0) = 0;
  - |x| ≥ 4.0 gives exactly ±1.0 (0x0100 / 0xFF00 at defaults);
  - absolute error ≤ 2^-5 (8 LSB) elsewhere;
  - monotonic non-decreasing.

Decomposition:
- Shared package lstm_pkg:
  - ew_state_t enum;
  - saturate and fixed-point-multiply functions parameterised on DATA_WIDTH/FRAC_BITS;
  - ONE_FX constant;
  - TANH_SAT_X constant (4.0).
- Sub-module lstm_tanh_pwl: piecewise-linear tanh, start/done handshake, fixed TANH_LAT pipeline, one operation in flight.

Test Plan:
- seq_idx=1, i=g=f=0x0080, c_prev=0x0100, then o=0x0100 → cell_state=0x00C0 at E2; hyperbolic_done at E3+TANH_LAT-1; hidden_state within ±8 LSB of 0x00A2.
- Same operands with seq_idx=0 → cell_state=0x0040 (c_prev ignored); h within ±8 of 0x0040.
- i=g=f=c_prev=0x7FFF, o=0x0100 → cell_state=0x7FFF (saturated), h=0x0100 exactly. All operands 0x8000, o=0x0100 → cell_state=0x7FFF (positive products), h=0x0100 exactly.
- f=0x0100, c_prev=0xFE00, i=0, o=0x0080 → cell_state=0xFE00, h within ±8 of 0xFF85.
- start_EW pulsed again while in TANH_WAIT → ignored, overrun_err=1, the first result is still correct, and exactly one cell_state_valid and one hidden_state_valid pulse are seen.
- rst_n low during WAIT_O, then o valid → no hidden_state_valid; all outputs 0. After reset, a clean run produces correct results.
